wrr_fifo_read_scheduler: RTL and testbench

- Read-side scheduler for a bank of four 8-entry FIFO_8-style queues (A..D).
- Mirrors each queue's occupancy from the write enables and the reads it issues itself.
- Picks one non-empty queue per cycle using weighted round-robin and drives that queue's one-hot read enable.
- Registers the selected head word onto a single output port with a valid flag and the granted queue ID; it replaces fixed-rotation arbitration, which wastes slots on empty queues.

---
 rtl/wrr_fifo_read_scheduler.sv | 163 ++++++++++++++++
 tb/tb_wrr_fifo_read_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_fifo_read_scheduler.sv
// Weighted round-robin read scheduler for four 8-entry FIFOs: mirrors occupancy, issues one-hot reads.
// Build option: define SCHED_WEIGHT_EN to honour the weight port; otherwise plain round-robin.
module wrr_fifo_read_scheduler #(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int WEIGHT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            wen,
    input  logic [4*WEIGHT_W-1:0] weight,
    input  logic [4*DW-1:0]       q_head,
    output logic [3:0]            ren,
    output logic [DW-1:0]         dout,
    output logic                  valid,
    output logic [1:0]            grant_id,
    output logic [3:0]            empty,
    output logic [3:0]            full,
    output logic                  drop
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Credit reload goes through this mask so the unweighted build keeps credit at zero.
`ifdef SCHED_WEIGHT_EN
    localparam logic [WEIGHT_W-1:0] WEIGHT_MASK = '1;
`else
    localparam logic [WEIGHT_W-1:0] WEIGHT_MASK = '0;
`endif

    typedef enum logic {IDLE, SERVE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       occ_q [4];
    logic [CW-1:0]       occ_d [4];
    logic [1:0]          ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic                valid_q, valid_d;
    logic [1:0]          gid_q, gid_d;
    logic                drop_q, drop_d;

    logic [WEIGHT_W-1:0] w_arr [4];
    logic [DW-1:0]       head_arr [4];
    logic [3:0]          empty_w, full_w, elig;
    logic [3:0]          ren_w;
    logic                grant;
    logic [1:0]          sel;
    logic [2:0]          scan;

    // Returns {found, index} of the first eligible queue scanning start, start+1, .. (mod 4).
    function automatic logic [2:0] first_eligible(input logic [3:0] elig_v, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && elig_v[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_arr[i]    = weight[i*WEIGHT_W +: WEIGHT_W];
            head_arr[i] = q_head[i*DW +: DW];
            empty_w[i]  = (occ_q[i] == '0);
            full_w[i]   = (occ_q[i] == CW'(DEPTH));
        end
        // A queue being written this cycle is never read in the same cycle.
        elig = ~empty_w & ~wen;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        grant    = 1'b0;
        sel      = ptr_q;
        scan     = first_eligible(elig, (state_q == SERVE) ? (ptr_q + 2'd1) : ptr_q);

        case (state_q)
            IDLE: begin
                if (scan[2]) begin
                    grant    = 1'b1;
                    sel      = scan[1:0];
                    ptr_d    = scan[1:0];
                    credit_d = w_arr[scan[1:0]] & WEIGHT_MASK;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                if ((credit_q != '0) && elig[ptr_q]) begin
                    grant    = 1'b1;
                    sel      = ptr_q;
                    credit_d = credit_q - WEIGHT_W'(1);
                end else if (scan[2]) begin
                    // Turn handover happens in the same cycle, so there is no bubble.
                    grant    = 1'b1;
                    sel      = scan[1:0];
                    ptr_d    = scan[1:0];
                    credit_d = w_arr[scan[1:0]] & WEIGHT_MASK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ren_w = grant ? (4'b0001 << sel) : 4'b0000;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            occ_d[i] = occ_q[i];
            if (wen[i] && !full_w[i]) begin
                occ_d[i] = occ_q[i] + CW'(1);
            end else if (ren_w[i]) begin
                occ_d[i] = occ_q[i] - CW'(1);
            end
        end
        drop_d  = |(wen & full_w);
        valid_d = grant;
        dout_d  = grant ? head_arr[sel] : '0;
        gid_d   = grant ? sel : gid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                occ_q[i] <= '0;
            end
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            credit_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            gid_q    <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                occ_q[i] <= occ_d[i];
            end
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            gid_q    <= gid_d;
            drop_q   <= drop_d;
        end
    end

    assign ren      = ren_w;
    assign dout     = dout_q;
    assign valid    = valid_q;
    assign grant_id = gid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign drop     = drop_q;

endmodule

// File: tb/tb_wrr_fifo_read_scheduler.sv
// Bench for wrr_fifo_read_scheduler: directed tables and sequences plus random traffic vs a turn-based model.
module tb_wrr_fifo_read_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wen;
    logic [7:0]  weight;
    logic [31:0] q_head;
    logic [3:0]  ren;
    logic [7:0]  dout;
    logic        valid;
    logic [1:0]  grant_id;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic        drop;

    always #5 clk = ~clk;

    wrr_fifo_read_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .weight   (weight),
        .q_head   (q_head),
        .ren      (ren),
        .dout     (dout),
        .valid    (valid),
        .grant_id (grant_id),
        .empty    (empty),
        .full     (full),
        .drop     (drop)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // The four queues themselves, plus the scheduler's turn state as grants left in the current turn.
    logic [7:0] fifo [4][$];
    int         m_ptr;
    int         m_left;
    bit         m_active;
    bit         exp_valid;
    logic [7:0] exp_dout;
    int         exp_gid;
    bit         exp_drop;

    logic [3:0] s_ren, s_empty, s_full;
    logic       s_valid, s_drop;
    logic [7:0] s_dout;
    logic [1:0] s_gid;

    typedef struct {
        logic [3:0] wen;
        logic [7:0] wdata;
        logic [3:0] ren;
        logic       valid;
        logic [7:0] dout;
        logic       empty0;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic int turn_len(input logic [7:0] wt, input int q);
`ifdef SCHED_WEIGHT_EN
        return int'(wt[q*2 +: 2]) + 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_left    = 0;
        m_active  = 0;
        exp_valid = 0;
        exp_dout  = 8'h00;
        exp_gid   = 0;
        exp_drop  = 0;
        for (int i = 0; i < 4; i++) fifo[i].delete();
    endtask

    // One clock: drive at negedge, check before the rising edge, update model after it.
    task automatic cycle(input logic [3:0] w, input logic [7:0] wt, input logic [7:0] d);
        logic [3:0] el, er, full_m, empty_m;
        int         g, start, n_left, n_ptr, ng;
        bit         nv;
        logic [7:0] nd;
        wen    = w;
        weight = wt;
        for (int i = 0; i < 4; i++) q_head[i*8 +: 8] = (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
        #1;
        for (int i = 0; i < 4; i++) begin
            empty_m[i] = (fifo[i].size() == 0);
            full_m[i]  = (fifo[i].size() == 8);
            el[i]      = !empty_m[i] && !w[i];
        end
        g      = -1;
        n_left = 0;
        n_ptr  = m_ptr;
        if (m_active && m_left > 0 && el[m_ptr]) begin
            g      = m_ptr;
            n_left = m_left - 1;
        end else begin
            start = m_active ? m_ptr + 1 : m_ptr;
            for (int k = 0; k < 4; k++) if (g < 0 && el[(start + k) % 4]) g = (start + k) % 4;
            if (g >= 0) begin
                n_left = turn_len(wt, g) - 1;
                n_ptr  = g;
            end
        end
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;

        s_ren = ren; s_empty = empty; s_full = full; s_valid = valid;
        s_dout = dout; s_gid = grant_id; s_drop = drop;
        check("ren", s_ren, er);
        check("empty", s_empty, empty_m);
        check("full", s_full, full_m);
        check("valid", s_valid, exp_valid);
        check("dout", s_dout, exp_dout);
        if (exp_valid) check("grant_id", s_gid, exp_gid);
        check("drop", s_drop, exp_drop);

        nv = (g >= 0);
        nd = (g >= 0) ? fifo[g][0] : 8'h00;
        ng = (g >= 0) ? g : exp_gid;
        @(posedge clk);
        m_ptr     = n_ptr;
        m_left    = n_left;
        m_active  = (g >= 0);
        exp_valid = nv;
        exp_dout  = nd;
        exp_gid   = ng;
        exp_drop  = |(w & full_m);
        for (int i = 0; i < 4; i++) begin
            if (s_ren[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
            if (w[i] && !full_m[i]) fifo[i].push_back(d + 8'(i * 64));
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[6];
        int   gids[$];
        int   exp_seq[8];
        int   first_v, last_v, reads;
        logic [3:0] w;

        tbl[0] = '{4'b0001, 8'h11, 4'b0000, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{4'b0001, 8'h22, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{4'b0000, 8'h00, 4'b0001, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{4'b0000, 8'h00, 4'b0001, 1'b1, 8'h11, 1'b0};
        tbl[4] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 8'h22, 1'b1};
        tbl[5] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 8'h00, 1'b1};
`ifdef SCHED_WEIGHT_EN
        exp_seq = '{0, 0, 1, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif

        rst_n = 1'b0; wen = 4'b0; weight = 8'h00; q_head = 32'h0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_ren", ren, 4'b0000);
        check("rst_valid", valid, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_gid", grant_id, 2'd0);
        check("rst_empty", empty, 4'b1111);
        check("rst_full", full, 4'b0000);
        check("rst_drop", drop, 1'b0);
        rst_n = 1'b1;

        // Two words into A, then drain.
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].wen, 8'h00, tbl[i].wdata);
            check("tbl_ren", s_ren, tbl[i].ren);
            check("tbl_valid", s_valid, tbl[i].valid);
            check("tbl_dout", s_dout, tbl[i].dout);
            check("tbl_empty0", s_empty[0], tbl[i].empty0);
            if (tbl[i].valid) check("tbl_gid", s_gid, 2'd0);
        end

        // Weighted: A weight 1, B weight 0, four words each.
        for (int i = 0; i < 4; i++) cycle(4'b0011, 8'h01, 8'(8'h30 + i));
        first_v = -1; last_v = -1;
        for (int c = 0; c < 12; c++) begin
            cycle(4'b0000, 8'h01, 8'h00);
            if (s_valid) begin
                gids.push_back(int'(s_gid));
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("wrr_count", gids.size(), 8);
        check("wrr_span", last_v - first_v + 1, 8);
        for (int k = 0; k < 8; k++) check("wrr_seq", (k < gids.size()) ? gids[k] : 99, exp_seq[k]);

        // Only C holds data: three back-to-back reads, then idle.
        for (int i = 0; i < 3; i++) cycle(4'b0100, 8'h00, 8'(8'h50 + i));
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0000, 8'h00, 8'h00);
            check("c_only_ren", s_ren, 4'b0100);
        end
        cycle(4'b0000, 8'h00, 8'h00);
        check("c_only_idle", s_ren, 4'b0000);

        // Nine writes to D: full after eight, drop after the ninth, eight reads on drain.
        for (int i = 0; i < 8; i++) cycle(4'b1000, 8'h00, 8'(8'h70 + i));
        check("d_full", full, 4'b1000);
        cycle(4'b1000, 8'h00, 8'h7f);
        check("d_drop", drop, 1'b1);
        reads = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(4'b0000, 8'h00, 8'h00);
            if (s_ren != 4'b0000) reads++;
        end
        check("d_reads", reads, 8);
        check("d_drop_clear", drop, 1'b0);

        // Owner A is written mid-turn: the turn passes to B with no drop.
        cycle(4'b0011, 8'h03, 8'h90);
        cycle(4'b0011, 8'h03, 8'h91);
        cycle(4'b0001, 8'h03, 8'h92);
        cycle(4'b0000, 8'h03, 8'h00);
        check("own_first", s_ren, 4'b0001);
        cycle(4'b0001, 8'h03, 8'h93);
        check("own_pass", s_ren, 4'b0010);
        cycle(4'b0000, 8'h03, 8'h00);
        check("own_nodrop", s_drop, 1'b0);
        for (int c = 0; c < 8; c++) cycle(4'b0000, 8'h03, 8'h00);
        check("own_drained", empty, 4'b1111);

        // Asynchronous reset in the middle of a turn.
        for (int i = 0; i < 4; i++) cycle(4'b0001, 8'h02, 8'(8'ha0 + i));
        cycle(4'b0000, 8'h02, 8'h00);
        cycle(4'b0000, 8'h02, 8'h00);
        #2;
        check("mid_valid", valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid, 1'b0);
        check("arst_dout", dout, 8'h00);
        check("arst_ren", ren, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("arst_empty", empty, 4'b1111);
        check("arst_full", full, 4'b0000);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) w[i] = ($urandom_range(0, (c < 300) ? 1 : 4) == 0);
            if ($urandom_range(0, 9) == 0) weight = 8'($urandom);
            cycle(w, weight, 8'($urandom));
        end
        for (int c = 0; c < 40; c++) cycle(4'b0000, weight, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
